// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared sizing constants and waveform encodings for the TDM
//                voice oscillator slice.
//  Contents    : NUM_VOICES, CHANBITS, D_W, PHASE_W, SHAPE_W, wave_e
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int NUM_VOICES = 4;   // TDM voice slots per frame
    localparam int CHANBITS   = 2;   // voice index width
    localparam int D_W        = 16;  // sample width, fix15 unsigned
    localparam int PHASE_W    = 24;  // phase accumulator width
    localparam int SHAPE_W    = 16;  // phase bits seen by the wave shaper

    typedef enum logic [1:0] {
        WAVE_SAW     = 2'd0,
        WAVE_SQUARE  = 2'd1,
        WAVE_TRI     = 2'd2,
        WAVE_SILENCE = 2'd3
    } wave_e;

endpackage
`default_nettype wire

// File: rtl/tdm_voice_oscillator_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_voice_oscillator_if
//  Description : Configuration write bus for the TDM voice oscillator.
//                The host (master) presents a voice configuration with
//                cfg_we; the oscillator (slave) takes it when cfg_ready=1.
//  Signals     : cfg_we, cfg_voice, cfg_inc, cfg_wave, cfg_gate  (master->slave)
//                cfg_ready                                     (slave->master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface tdm_voice_oscillator_if #(
    parameter int CHANBITS = synth_pkg::CHANBITS,
    parameter int PHASE_W  = synth_pkg::PHASE_W
);

    logic                cfg_we;
    logic [CHANBITS-1:0] cfg_voice;
    logic [PHASE_W-1:0]  cfg_inc;
    logic [1:0]          cfg_wave;
    logic                cfg_gate;
    logic                cfg_ready;

    modport master (
        output cfg_we, cfg_voice, cfg_inc, cfg_wave, cfg_gate,
        input  cfg_ready
    );

    modport slave (
        input  cfg_we, cfg_voice, cfg_inc, cfg_wave, cfg_gate,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/voice_wave_shaper.sv
`default_nettype none
// ============================================================================
//  Module      : voice_wave_shaper
//  Description : Combinational phase-to-sample mapping. Takes the top 16
//                phase bits of one voice and produces a fix15 unsigned sample
//                in [0, 0x7FFF]. A low gate forces silence.
//  Ports       : phase_msb (in 16), wave (in 2), gate (in 1),
//                sample (out D_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_wave_shaper #(
    parameter int D_W = synth_pkg::D_W
) (
    input  logic [15:0]    phase_msb,
    input  logic [1:0]     wave,
    input  logic           gate,
    output logic [D_W-1:0] sample
);
    import synth_pkg::*;

    logic [15:0] w_shape;

    always_comb begin
        w_shape = 16'h0000;
        if (gate) begin
            case (wave_e'(wave))
                WAVE_SAW:     w_shape = {1'b0, phase_msb[15:1]};
                WAVE_SQUARE:  w_shape = phase_msb[15] ? 16'h7FFF : 16'h0000;
                // Fold the second half of the cycle back down.
                WAVE_TRI:     w_shape = {1'b0, phase_msb[15] ? ~phase_msb[14:0]
                                                             :  phase_msb[14:0]};
                default:      w_shape = 16'h0000;
            endcase
        end
    end

    assign sample = D_W'(w_shape);

endmodule
`default_nettype wire

// File: rtl/tdm_voice_oscillator.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_voice_oscillator
//  Description : Time-multiplexed phase-accumulator oscillator. One voice
//                slot is serviced per enabled cycle; each slot issues the
//                sample of its pre-update phase and then advances the phase.
//                Configuration writes pass through a single-entry buffer that
//                commits only when it cannot collide with the target voice's
//                own phase update.
//  Ports       : dsp_clk, rst_n (async, active low), dsp_enable,
//                cfg (config bus, slave modport),
//                chan_out, data_out, chan_enabled_out, frame_start
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_voice_oscillator #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int CHANBITS   = synth_pkg::CHANBITS,
    parameter int D_W        = synth_pkg::D_W,
    parameter int PHASE_W    = synth_pkg::PHASE_W
) (
    input  logic                   dsp_clk,
    input  logic                   rst_n,
    input  logic                   dsp_enable,
    tdm_voice_oscillator_if.slave  cfg,
    output logic [CHANBITS-1:0]    chan_out,
    output logic [D_W-1:0]         data_out,
    output logic                   chan_enabled_out,
    output logic                   frame_start
);
    import synth_pkg::*;

    localparam logic [CHANBITS-1:0] C_LAST_SLOT = CHANBITS'(NUM_VOICES - 1);

    // Per-voice state, indexed by slot
    logic [CHANBITS-1:0] r_slot;
    logic [PHASE_W-1:0]  r_phase [NUM_VOICES];
    logic [PHASE_W-1:0]  r_inc   [NUM_VOICES];
    wave_e               r_wave  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate;

    // Single-entry configuration buffer
    logic                r_buf_valid;
    logic [CHANBITS-1:0] r_buf_voice;
    logic [PHASE_W-1:0]  r_buf_inc;
    wave_e               r_buf_wave;
    logic                r_buf_gate;

    logic [PHASE_W-1:0]  w_cur_phase;
    logic [D_W-1:0]      w_sample;
    logic                w_commit;
    logic                w_accept;

    assign w_cur_phase = r_phase[r_slot];

    // Hold the buffer back while its voice is the one being updated this
    // cycle, so a voice never mixes old and new configuration in one step.
    assign w_commit = r_buf_valid && (!dsp_enable || (r_slot != r_buf_voice));
    assign w_accept = cfg.cfg_we && !r_buf_valid;

    assign cfg.cfg_ready = ~r_buf_valid;

    voice_wave_shaper #(
        .D_W (D_W)
    ) u_shaper (
        .phase_msb (w_cur_phase[PHASE_W-1 -: SHAPE_W]),
        .wave      (r_wave[r_slot]),
        .gate      (r_gate[r_slot]),
        .sample    (w_sample)
    );

    always_ff @(posedge dsp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot           <= '0;
            r_gate           <= '0;
            r_buf_valid      <= 1'b0;
            r_buf_voice      <= '0;
            r_buf_inc        <= '0;
            r_buf_wave       <= WAVE_SILENCE;
            r_buf_gate       <= 1'b0;
            chan_out         <= '0;
            data_out         <= '0;
            chan_enabled_out <= 1'b0;
            frame_start      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
                r_inc[i]   <= '0;
                r_wave[i]  <= WAVE_SILENCE;
            end
        end else begin
            // frame_start marks a freshly issued slot-0 sample only
            frame_start <= dsp_enable && (r_slot == '0);

            if (dsp_enable) begin
                chan_out         <= r_slot;
                data_out         <= w_sample;
                chan_enabled_out <= r_gate[r_slot];
                r_phase[r_slot]  <= r_gate[r_slot] ? (w_cur_phase + r_inc[r_slot]) : '0;
                r_slot           <= (r_slot == C_LAST_SLOT) ? '0 : (r_slot + 1'b1);
            end

            if (w_commit) begin
                r_inc[r_buf_voice]  <= r_buf_inc;
                r_wave[r_buf_voice] <= r_buf_wave;
                r_gate[r_buf_voice] <= r_buf_gate;
                r_buf_valid         <= 1'b0;
            end else if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_voice <= cfg.cfg_voice;
                r_buf_inc   <= cfg.cfg_inc;
                r_buf_wave  <= wave_e'(cfg.cfg_wave);
                r_buf_gate  <= cfg.cfg_gate;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_voice_oscillator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_voice_oscillator
//  Description : Self-checking bench for tdm_voice_oscillator. A table of
//                directed vectors covers the basic slot rotation; hand-written
//                sequences cover configuration, buffering, freeze and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_voice_oscillator;

    logic        dsp_clk;
    logic        rst_n;
    logic        dsp_enable;
    logic [1:0]  chan_out;
    logic [15:0] data_out;
    logic        chan_enabled_out;
    logic        frame_start;

    int n_pass  = 0;
    int n_total = 0;

    tdm_voice_oscillator_if #(.CHANBITS(2), .PHASE_W(24)) cfg_if ();

    tdm_voice_oscillator #(
        .NUM_VOICES (4),
        .CHANBITS   (2),
        .D_W        (16),
        .PHASE_W    (24)
    ) dut (
        .dsp_clk          (dsp_clk),
        .rst_n            (rst_n),
        .dsp_enable       (dsp_enable),
        .cfg              (cfg_if),
        .chan_out         (chan_out),
        .data_out         (data_out),
        .chan_enabled_out (chan_enabled_out),
        .frame_start      (frame_start)
    );

    initial dsp_clk = 1'b0;
    always #5 dsp_clk = ~dsp_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en;
        logic [1:0]  chan;
        logic [15:0] data;
        logic        chen;
        logic        fs;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge dsp_clk);
        #1;
    endtask

    // Advance at least one cycle, then until chan_out shows voice v.
    task automatic wait_chan(input logic [1:0] v);
        int n;
        n = 0;
        tick();
        while (chan_out !== v && n < 8) begin
            tick();
            n++;
        end
        if (chan_out !== v) chk("wait_chan timeout", 32'(chan_out), 32'(v));
    endtask

    task automatic set_cfg(input logic we, input logic [1:0] v, input logic [23:0] inc,
                           input logic [1:0] w, input logic g);
        cfg_if.cfg_we    = we;
        cfg_if.cfg_voice = v;
        cfg_if.cfg_inc   = inc;
        cfg_if.cfg_wave  = w;
        cfg_if.cfg_gate  = g;
    endtask

    // Write through the buffer with dsp_enable low: accept edge, commit edge.
    task automatic idle_write(input logic [1:0] v, input logic [23:0] inc,
                              input logic [1:0] w, input logic g);
        dsp_enable = 1'b0;
        set_cfg(1'b1, v, inc, w, g);
        tick();
        chk("idle_write ready low after accept", 32'(cfg_if.cfg_ready), 32'd0);
        cfg_if.cfg_we = 1'b0;
        tick();
        chk("idle_write ready high after commit", 32'(cfg_if.cfg_ready), 32'd1);
    endtask

    logic [15:0] sq_exp [6];

    initial begin
        vecs[0] = '{en: 1'b1, chan: 2'd0, data: 16'h0000, chen: 1'b0, fs: 1'b1};
        vecs[1] = '{en: 1'b1, chan: 2'd1, data: 16'h0000, chen: 1'b0, fs: 1'b0};
        vecs[2] = '{en: 1'b1, chan: 2'd2, data: 16'h0000, chen: 1'b0, fs: 1'b0};
        vecs[3] = '{en: 1'b1, chan: 2'd3, data: 16'h0000, chen: 1'b0, fs: 1'b0};
        vecs[4] = '{en: 1'b1, chan: 2'd0, data: 16'h0000, chen: 1'b0, fs: 1'b1};
        vecs[5] = '{en: 1'b0, chan: 2'd0, data: 16'h0000, chen: 1'b0, fs: 1'b0};

        sq_exp[0] = 16'h0000; sq_exp[1] = 16'h0000; sq_exp[2] = 16'h7FFF;
        sq_exp[3] = 16'h7FFF; sq_exp[4] = 16'h0000; sq_exp[5] = 16'h0000;

        // ---------------- reset state ----------------
        rst_n      = 1'b0;
        dsp_enable = 1'b0;
        set_cfg(1'b0, 2'd0, 24'd0, 2'd3, 1'b0);
        tick();
        tick();
        chk("reset chan_out", 32'(chan_out), 32'd0);
        chk("reset data_out", 32'(data_out), 32'd0);
        chk("reset chan_enabled_out", 32'(chan_enabled_out), 32'd0);
        chk("reset frame_start", 32'(frame_start), 32'd0);
        chk("reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // ---------------- slot rotation table ----------------
        for (int i = 0; i < 6; i++) begin
            dsp_enable = vecs[i].en;
            tick();
            chk($sformatf("vec%0d chan_out", i), 32'(chan_out), 32'(vecs[i].chan));
            chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].data));
            chk($sformatf("vec%0d chan_enabled_out", i), 32'(chan_enabled_out), 32'(vecs[i].chen));
            chk($sformatf("vec%0d frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
        end

        // ---------------- voice 1 saw, inc 0x010000 ----------------
        idle_write(2'd1, 24'h010000, 2'd0, 1'b1);
        dsp_enable = 1'b1;
        wait_chan(2'd1);
        chk("saw v1 sample0", 32'(data_out), 32'h0000);
        chk("saw v1 gate", 32'(chan_enabled_out), 32'd1);
        wait_chan(2'd1);
        chk("saw v1 sample1", 32'(data_out), 32'h0080);
        wait_chan(2'd1);
        chk("saw v1 sample2", 32'(data_out), 32'h0100);
        for (int k = 0; k < 252; k++) wait_chan(2'd1);
        wait_chan(2'd1);
        chk("saw v1 sample255", 32'(data_out), 32'h7F80);
        wait_chan(2'd1);
        chk("saw v1 wrap to 0", 32'(data_out), 32'h0000);

        // ---------------- voice 2 square, written while running ----------------
        set_cfg(1'b1, 2'd2, 24'h400000, 2'd1, 1'b1);
        tick();
        cfg_if.cfg_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_chan(2'd2);
            chk($sformatf("square v2 sample%0d", k), 32'(data_out), 32'(sq_exp[k]));
        end

        // ---------------- collision: write to the voice updating next ----------------
        wait_chan(2'd1);                       // slot 2 is next, slot 3 after
        set_cfg(1'b1, 2'd3, 24'h100000, 2'd2, 1'b1);
        tick();                                // accept; slot 2 issued
        chk("collide ready low cycle1", 32'(cfg_if.cfg_ready), 32'd0);
        set_cfg(1'b1, 2'd0, 24'h800000, 2'd1, 1'b1);  // must be ignored
        tick();                                // slot 3 updates, commit held
        chk("collide ready low cycle2", 32'(cfg_if.cfg_ready), 32'd0);
        chk("collide v3 old gate", 32'(chan_enabled_out), 32'd0);
        chk("collide v3 old data", 32'(data_out), 32'h0000);
        tick();                                // commit
        chk("collide ready high cycle3", 32'(cfg_if.cfg_ready), 32'd1);
        cfg_if.cfg_we = 1'b0;
        wait_chan(2'd3);
        chk("tri v3 sample0", 32'(data_out), 32'h0000);
        chk("tri v3 gate", 32'(chan_enabled_out), 32'd1);
        wait_chan(2'd0);
        chk("busy write ignored v0 gate", 32'(chan_enabled_out), 32'd0);
        wait_chan(2'd3);
        chk("tri v3 sample1", 32'(data_out), 32'h1000);

        // ---------------- freeze for 10 cycles ----------------
        dsp_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("freeze%0d chan_out", k), 32'(chan_out), 32'd3);
            chk($sformatf("freeze%0d data_out", k), 32'(data_out), 32'h1000);
        end
        dsp_enable = 1'b1;
        tick();
        chk("resume next slot", 32'(chan_out), 32'd0);
        wait_chan(2'd3);
        chk("tri v3 after freeze", 32'(data_out), 32'h2000);

        // ---------------- gate clear zeroes phase ----------------
        idle_write(2'd3, 24'h100000, 2'd2, 1'b0);
        dsp_enable = 1'b1;
        wait_chan(2'd3);
        chk("gate off v3 data", 32'(data_out), 32'h0000);
        chk("gate off v3 chen", 32'(chan_enabled_out), 32'd0);
        idle_write(2'd3, 24'h100000, 2'd2, 1'b1);
        dsp_enable = 1'b1;
        wait_chan(2'd3);
        chk("regate v3 phase restarted", 32'(data_out), 32'h0000);
        wait_chan(2'd3);
        chk("regate v3 sample1", 32'(data_out), 32'h1000);

        // ---------------- reset with a write buffered ----------------
        set_cfg(1'b1, 2'd0, 24'h800000, 2'd1, 1'b1);
        tick();
        cfg_if.cfg_we = 1'b0;
        chk("pre-reset buffer busy", 32'(cfg_if.cfg_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset chan_out", 32'(chan_out), 32'd0);
        chk("async reset data_out", 32'(data_out), 32'd0);
        chk("async reset chan_enabled_out", 32'(chan_enabled_out), 32'd0);
        chk("async reset frame_start", 32'(frame_start), 32'd0);
        chk("async reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post-reset first chan", 32'(chan_out), 32'd0);
        chk("post-reset frame_start", 32'(frame_start), 32'd1);
        chk("post-reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        wait_chan(2'd0);
        chk("discarded write v0 gate", 32'(chan_enabled_out), 32'd0);
        chk("discarded write v0 data", 32'(data_out), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
